// File: rtl/led_seq_pkg.sv
// Shared mode encoding and reset pattern for the LED sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_STOP = 2'b00,
    MODE_FWD  = 2'b01,
    MODE_REV  = 2'b10,
    MODE_MAN  = 2'b11
  } mode_e;

  // Reset pattern: 0 = ch2, 1 = ch1, 2 = ch0, 3 = all channels; later entries dark.
  function automatic logic default_full(input int entry, input int ch);
    case (entry)
      0:       return (ch == 2);
      1:       return (ch == 1);
      2:       return (ch == 0);
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pwm_cmp.sv
// Shared free-running PWM counter feeding one registered comparator per channel.
module pwm_cmp #(
  parameter int NCH   = 3,
  parameter int PWM_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*PWM_W-1:0]   duty,
  output logic [NCH-1:0]         led
);

  logic [PWM_W-1:0] pc;

  // Strict less-than: full duty still leaves one dark slot per period.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= '0;
      led <= '0;
    end else begin
      pc <= pc + 1'b1;
      for (int c = 0; c < NCH; c++)
        led[c] <= (pc < duty[c*PWM_W +: PWM_W]);
    end
  end

endmodule

// File: rtl/led_seq_pwm.sv
// Multi-channel LED sequencer: steps through a writable duty table in
// stop / forward / reverse / manual modes and drives PWM outputs.
module led_seq_pwm
  import led_seq_pkg::*;
#(
  parameter int NCH    = 3,
  parameter int PWM_W  = 4,
  parameter int DIV_W  = 26,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             MODE,
  input  logic                   STEP,
  input  logic [ADDR_W-1:0]      LAST,
  input  logic                   WE,
  input  logic [ADDR_W-1:0]      WADDR,
  input  logic [NCH*PWM_W-1:0]   WDATA,
  output logic [NCH-1:0]         LED,
  output logic [ADDR_W-1:0]      STEP_IDX,
  output logic                   WRAP
);

  localparam int DW = NCH * PWM_W;

  logic [DIV_W-1:0]          div;
  logic [DEPTH-1:0][DW-1:0]  tbl;
  logic [ADDR_W-1:0]         idx;
  logic                      wrap;
  logic                      tick, rev, adv;

  always_comb begin
    tick = &div;
    rev  = (MODE == MODE_REV);
    adv  = (((MODE == MODE_FWD) || rev) && tick) || ((MODE == MODE_MAN) && STEP);
  end

  always_ff @(posedge CLK) begin
    if (RST) div <= '0;
    else     div <= div + 1'b1;
  end

  // Register array rather than RAM so reset can restore the default pattern.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int e = 0; e < DEPTH; e++)
        for (int c = 0; c < NCH; c++)
          tbl[e][c*PWM_W +: PWM_W] <= {PWM_W{default_full(e, c)}};
    end else if (WE) begin
      tbl[WADDR] <= WDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (adv) begin
        if (rev) begin
          // Out-of-range index (LAST lowered) snaps to LAST like a wrap.
          if (idx == '0 || idx > LAST) begin
            idx  <= LAST;
            wrap <= 1'b1;
          end else begin
            idx <= idx - 1'b1;
          end
        end else begin
          if (idx >= LAST) begin
            idx  <= '0;
            wrap <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
      end
    end
  end

  assign STEP_IDX = idx;
  assign WRAP     = wrap;

  pwm_cmp #(.NCH(NCH), .PWM_W(PWM_W)) u_pwm (
    .clk  (CLK),
    .rst  (RST),
    .duty (tbl[idx]),
    .led  (LED)
  );

endmodule

// File: tb/tb_led_seq_pwm.sv
// Directed bench for led_seq_pwm with a 16-cycle step tick.
module tb_led_seq_pwm;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  MODE;
  logic        STEP;
  logic [2:0]  LAST;
  logic        WE;
  logic [2:0]  WADDR;
  logic [11:0] WDATA;
  logic [2:0]  LED;
  logic [2:0]  STEP_IDX;
  logic        WRAP;

  int checks = 0;
  int errors = 0;

  led_seq_pwm #(.NCH(3), .PWM_W(4), .DIV_W(4), .DEPTH(8), .ADDR_W(3)) dut (
    .CLK(CLK), .RST(RST), .MODE(MODE), .STEP(STEP), .LAST(LAST),
    .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .LED(LED), .STEP_IDX(STEP_IDX), .WRAP(WRAP)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic test_reset();
    RST = 1'b1; MODE = 2'b01; STEP = 1'b0; LAST = 3'd4;
    WE = 1'b0; WADDR = '0; WDATA = '0;
    repeat (3) @(negedge CLK);
    checks++;
    if (STEP_IDX !== 3'd0 || LED !== 3'b000 || WRAP !== 1'b0) begin
      errors++;
      $display("FAIL reset: idx=%0d led=%b wrap=%b, want 0 000 0", STEP_IDX, LED, WRAP);
    end
    RST = 1'b0;
  endtask

  // Called right after reset release, so the first tick edge is 16 cycles out.
  task automatic test_fwd();
    int exp_idx[5] = '{1, 2, 3, 4, 0};
    int prev = 0, wraps = 0, led2 = 0, led10 = 0;
    for (int s = 0; s < 5; s++) begin
      for (int c = 1; c <= 16; c++) begin
        @(negedge CLK);
        wraps += WRAP;
        if (s == 0) begin
          led2  += LED[2];
          led10 += LED[1] + LED[0];
        end
        if (c == 15) begin
          checks++;
          if (STEP_IDX !== 3'(prev)) begin
            errors++;
            $display("FAIL fwd_hold s%0d: idx=%0d want %0d", s, STEP_IDX, prev);
          end
        end
        if (c == 16) begin
          checks++;
          if (STEP_IDX !== 3'(exp_idx[s]) || WRAP !== (s == 4)) begin
            errors++;
            $display("FAIL fwd_step s%0d: idx=%0d wrap=%b want %0d %b",
                     s, STEP_IDX, WRAP, exp_idx[s], (s == 4));
          end
        end
      end
      prev = exp_idx[s];
    end
    checks++;
    if (wraps != 1) begin errors++; $display("FAIL fwd_wrapcnt: got %0d want 1", wraps); end
    checks++;
    if (led2 != 15 || led10 != 0) begin
      errors++;
      $display("FAIL fwd_led_idx0: led2=%0d led10=%0d want 15 0", led2, led10);
    end
  endtask

  task automatic test_rev();
    int exp_idx[6] = '{4, 3, 2, 1, 0, 4};
    int wraps = 0;
    MODE = 2'b10;
    for (int s = 0; s < 6; s++) begin
      for (int c = 1; c <= 16; c++) begin
        @(negedge CLK);
        wraps += WRAP;
        if (c == 16) begin
          checks++;
          if (STEP_IDX !== 3'(exp_idx[s]) || WRAP !== (s == 0 || s == 5)) begin
            errors++;
            $display("FAIL rev_step s%0d: idx=%0d wrap=%b want %0d %b",
                     s, STEP_IDX, WRAP, exp_idx[s], (s == 0 || s == 5));
          end
        end
      end
    end
    checks++;
    if (wraps != 2) begin errors++; $display("FAIL rev_wrapcnt: got %0d want 2", wraps); end
    LAST = 3'd2;
    repeat (16) @(negedge CLK);
    checks++;
    if (STEP_IDX !== 3'd2 || WRAP !== 1'b1) begin
      errors++;
      $display("FAIL rev_last_lowered: idx=%0d wrap=%b want 2 1", STEP_IDX, WRAP);
    end
  endtask

  // Starts at idx 2; eight pulses with LAST=7 come back to 2 with one wrap.
  task automatic test_man();
    int wraps = 0, cur = 2;
    MODE = 2'b11; LAST = 3'd7;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      wraps += WRAP;
    end
    checks++;
    if (STEP_IDX !== 3'd2) begin errors++; $display("FAIL man_no_tick: idx=%0d want 2", STEP_IDX); end
    for (int k = 0; k < 8; k++) begin
      STEP = 1'b1;
      @(negedge CLK);
      STEP = 1'b0;
      wraps += WRAP;
      cur = (cur + 1) % 8;
      checks++;
      if (STEP_IDX !== 3'(cur)) begin
        errors++;
        $display("FAIL man_step k%0d: idx=%0d want %0d", k, STEP_IDX, cur);
      end
      repeat (2) begin @(negedge CLK); wraps += WRAP; end
    end
    checks++;
    if (wraps != 1) begin errors++; $display("FAIL man_wrapcnt: got %0d want 1", wraps); end
  endtask

  task automatic test_write();
    int n0 = 0, n1 = 0, n2 = 0;
    WE = 1'b1; WADDR = 3'd2; WDATA = {4'd0, 4'd8, 4'd1};
    @(negedge CLK);
    WE = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      n0 += LED[0]; n1 += LED[1]; n2 += LED[2];
    end
    checks++;
    if (n0 != 1 || n1 != 8 || n2 != 0) begin
      errors++;
      $display("FAIL write_duty: ch0=%0d ch1=%0d ch2=%0d want 1 8 0", n0, n1, n2);
    end
  endtask

  task automatic test_stop();
    int moved = 0, wraps = 0;
    logic [2:0] start;
    MODE = 2'b00;
    start = STEP_IDX;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      wraps += WRAP;
      if (STEP_IDX !== start) moved++;
    end
    checks++;
    if (moved != 0 || STEP_IDX !== 3'd2) begin
      errors++;
      $display("FAIL stop_hold: moved=%0d idx=%0d want 0 2", moved, STEP_IDX);
    end
    checks++;
    if (wraps != 0) begin errors++; $display("FAIL stop_wrap: got %0d want 0", wraps); end
  endtask

  task automatic test_reset_mid();
    int n0 = 0, n1 = 0, n2 = 0;
    WE = 1'b1; WADDR = 3'd0; WDATA = 12'h555;
    @(negedge CLK);
    RST = 1'b1; WADDR = 3'd0; WDATA = 12'h333;
    @(negedge CLK);
    checks++;
    if (STEP_IDX !== 3'd0 || LED !== 3'b000 || WRAP !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: idx=%0d led=%b wrap=%b want 0 000 0", STEP_IDX, LED, WRAP);
    end
    RST = 1'b0; WE = 1'b0; MODE = 2'b11;
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      n0 += LED[0]; n1 += LED[1]; n2 += LED[2];
    end
    checks++;
    if (n0 != 0 || n1 != 0 || n2 != 15) begin
      errors++;
      $display("FAIL reset_entry0: ch0=%0d ch1=%0d ch2=%0d want 0 0 15", n0, n1, n2);
    end
    // Entry 2 was overwritten earlier; it must be back to ch0 full.
    repeat (2) begin
      STEP = 1'b1; @(negedge CLK); STEP = 1'b0;
    end
    n0 = 0; n1 = 0; n2 = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      n0 += LED[0]; n1 += LED[1]; n2 += LED[2];
    end
    checks++;
    if (STEP_IDX !== 3'd2 || n0 != 15 || n1 != 0 || n2 != 0) begin
      errors++;
      $display("FAIL reset_entry2: idx=%0d ch0=%0d ch1=%0d ch2=%0d want 2 15 0 0",
               STEP_IDX, n0, n1, n2);
    end
  endtask

  task automatic test_back_to_back();
    int n0 = 0, n1 = 0, n2 = 0;
    STEP = 1'b1; WE = 1'b1; WADDR = 3'd3; WDATA = {4'd12, 4'd0, 4'd2};
    @(negedge CLK);
    STEP = 1'b0; WE = 1'b0;
    checks++;
    if (STEP_IDX !== 3'd3) begin errors++; $display("FAIL b2b_idx: idx=%0d want 3", STEP_IDX); end
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      n0 += LED[0]; n1 += LED[1]; n2 += LED[2];
    end
    checks++;
    if (n0 != 2 || n1 != 0 || n2 != 12) begin
      errors++;
      $display("FAIL b2b_duty: ch0=%0d ch1=%0d ch2=%0d want 2 0 12", n0, n1, n2);
    end
  endtask

  task automatic test_last_zero();
    LAST = 3'd0;
    for (int k = 0; k < 2; k++) begin
      STEP = 1'b1;
      @(negedge CLK);
      STEP = 1'b0;
      checks++;
      if (STEP_IDX !== 3'd0 || WRAP !== 1'b1) begin
        errors++;
        $display("FAIL last0_k%0d: idx=%0d wrap=%b want 0 1", k, STEP_IDX, WRAP);
      end
      @(negedge CLK);
      checks++;
      if (WRAP !== 1'b0) begin errors++; $display("FAIL last0_wrap_clear k%0d: wrap=%b want 0", k, WRAP); end
    end
  endtask

  initial begin
    test_reset();
    test_fwd();
    test_rev();
    test_man();
    test_write();
    test_stop();
    test_reset_mid();
    test_back_to_back();
    test_last_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
